// File: rtl/bram_access_sched.sv
// Read-port scheduler for one simple-dual-port BRAM: host reads and writes share the
// RAM with a sweep engine that forms an additive checksum over every word.
module bram_access_sched #(
  parameter int WID_MEM    = 9,
  parameter int ADDR_W     = 13,
  parameter int DEPTH_MEM  = 8192,
  parameter int SUM_W      = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_sweep,
  output logic               sweep_busy,
  output logic               sweep_done,
  output logic [SUM_W-1:0]   sweep_sum,
  input  logic               h_req,
  input  logic               h_we,
  input  logic [ADDR_W-1:0]  h_addr,
  input  logic [WID_MEM-1:0] h_wdata,
  output logic               h_gnt,
  output logic               h_rvalid,
  output logic [WID_MEM-1:0] h_rdata,
  output logic [ADDR_W-1:0]  mem_raddr,
  output logic [ADDR_W-1:0]  mem_waddr,
  output logic [WID_MEM-1:0] mem_din,
  output logic               mem_we,
  input  logic [WID_MEM-1:0] mem_dout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam int ST_W = $clog2(STARVE_LIM + 1);
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH_MEM - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ST_W-1:0] ST_LIM   = ST_W'(STARVE_LIM);
  localparam logic [ST_W-1:0] ST_ONE   = ST_W'(1);

  state_t             state_q,  state_d;
  logic [ADDR_W:0]    cnt_q,    cnt_d;
  logic [ST_W-1:0]    starve_q, starve_d;
  logic [ADDR_W-1:0]  raddr_q,  raddr_d;
  logic               issued_q, issued_d;
  logic               tag_q,    tag_d;
  logic [SUM_W-1:0]   sum_q,    sum_d;
  logic               done_q,   done_d;
  logic               rvalid_q, rvalid_d;
  logic [WID_MEM-1:0] rdata_q,  rdata_d;

  logic host_rd_s;
  logic host_rd_gnt_s;
  logic sweep_gnt_s;

  // Next-state logic: arbitration, sweep sequencing and read-return handling
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    starve_d      = starve_q;
    raddr_d       = raddr_q;
    issued_d      = 1'b0;
    tag_d         = tag_q;
    sum_d         = sum_q;
    done_d        = 1'b0;
    rvalid_d      = 1'b0;
    rdata_d       = rdata_q;
    host_rd_gnt_s = 1'b0;
    sweep_gnt_s   = 1'b0;
    host_rd_s     = h_req & ~h_we;

    // tag_q = 1 marks a sweep-owned read whose data is on mem_dout now
    if (issued_q) begin
      if (tag_q) begin
        sum_d = sum_q + {{(SUM_W - WID_MEM){1'b0}}, mem_dout};
      end else begin
        rvalid_d = 1'b1;
        rdata_d  = mem_dout;
      end
    end else begin
      rdata_d = rdata_q;
    end

    case (state_q)
      S_IDLE: begin
        starve_d      = {ST_W{1'b0}};
        host_rd_gnt_s = host_rd_s;
        if (start_sweep) begin
          state_d = S_SWEEP;
          cnt_d   = {(ADDR_W + 1){1'b0}};
          sum_d   = {SUM_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SWEEP: begin
        if (host_rd_s && (starve_q != ST_LIM)) begin
          host_rd_gnt_s = 1'b1;
          starve_d      = starve_q + ST_ONE;
        end else begin
          sweep_gnt_s = 1'b1;
          starve_d    = {ST_W{1'b0}};
          cnt_d       = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_SWEEP;
          end
        end
      end
      S_DRAIN: begin
        host_rd_gnt_s = host_rd_s;
        if (issued_q && tag_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (host_rd_gnt_s) begin
      issued_d = 1'b1;
      tag_d    = 1'b0;
      raddr_d  = h_addr;
    end else if (sweep_gnt_s) begin
      issued_d = 1'b1;
      tag_d    = 1'b1;
      raddr_d  = cnt_q[ADDR_W-1:0];
    end else begin
      issued_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= {(ADDR_W + 1){1'b0}};
      starve_q <= {ST_W{1'b0}};
      raddr_q  <= {ADDR_W{1'b0}};
      issued_q <= 1'b0;
      tag_q    <= 1'b0;
      sum_q    <= {SUM_W{1'b0}};
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= {WID_MEM{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      raddr_q  <= raddr_d;
      issued_q <= issued_d;
      tag_q    <= tag_d;
      sum_q    <= sum_d;
      done_q   <= done_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // The read address must reach the RAM in the grant cycle, so it bypasses the hold register
  assign mem_raddr  = raddr_d;
  assign mem_we     = ~reset & h_req & h_we;
  assign mem_waddr  = h_addr;
  assign mem_din    = h_wdata;
  assign h_gnt      = ~reset & h_req & (h_we | host_rd_gnt_s);
  assign h_rvalid   = rvalid_q;
  assign h_rdata    = rdata_q;
  assign sweep_busy = (state_q != S_IDLE);
  assign sweep_done = done_q;
  assign sweep_sum  = sum_q;

endmodule

// File: doc/bram_access_sched.md
Name: bram_access_sched

Overview:
- Access scheduler in front of one simple-dual-port block RAM: `WID_MEM` bits wide, `DEPTH_MEM` deep, registered read (1-cycle latency), read-first on same-address collision.
- Shares the RAM read port between two requesters:
  - a host port;
  - an internal sweep engine that reads every address once and forms an additive checksum. The checksum verifies RAM contents after bitstream-driven reinitialisation.
- Host writes go straight through the RAM write port. `mem_we` gates the RAM write.

Parameters:
- `WID_MEM`, 9, RAM word width.
- `ADDR_W`, 13, address width.
- `DEPTH_MEM`, 8192, words swept; must be ≤ 2^`ADDR_W`.
- `SUM_W`, 32, checksum width.
- `STARVE_LIM`, 4, maximum consecutive host-read grants while a sweep read is pending.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `start_sweep` in 1: begin sweep; sampled only in IDLE.
- `sweep_busy` out 1: high in SWEEP and DRAIN.
- `sweep_done` out 1: one-cycle pulse when the checksum is final.
- `sweep_sum` out `SUM_W`: checksum; held until the next sweep start.
- `h_req` in 1: host request valid.
- `h_we` in 1: 1 = write, 0 = read.
- `h_addr` in `ADDR_W`: host address.
- `h_wdata` in `WID_MEM`: host write data.
- `h_gnt` out 1: combinational grant; the request is consumed in this cycle.
- `h_rvalid` out 1: host read data valid.
- `h_rdata` out `WID_MEM`: host read data.
- `mem_raddr` out `ADDR_W`: RAM read address.
- `mem_waddr` out `ADDR_W`: RAM write address.
- `mem_din` out `WID_MEM`: RAM write data.
- `mem_we` out 1: RAM write enable.
- `mem_dout` in `WID_MEM`: RAM registered read data.

Behaviour:

Reset:
- State IDLE.
- `sweep_busy`, `sweep_done`, `h_rvalid`, `mem_we` = 0.
- `sweep_sum`, `h_rdata`, address counter, starvation counter, read tag = 0.
- Reset mid-sweep aborts with no `sweep_done` pulse and clears the checksum.

States:
- **IDLE**: on `start_sweep`, clear `sweep_sum` and the address counter, then go to SWEEP. The first read can issue in the next cycle.
- **SWEEP**: issue one sweep read per won read slot, at address = counter, then increment the counter. After the read of address `DEPTH_MEM`-1 is issued, go to DRAIN.
- **DRAIN**: wait until the last sweep data has been accumulated. Pulse `sweep_done` for 1 cycle, then go to IDLE.
- `start_sweep` outside IDLE is ignored.

Host writes:
- A write request (`h_req`=1, `h_we`=1) is always granted in the same cycle.
- `mem_we`=1, `mem_waddr`=`h_addr`, `mem_din`=`h_wdata`.
- Writes never contend with reads.

Read-port arbitration:
- One read per cycle.
- Host read pending and no sweep read pending: host wins.
- Both pending: host wins unless the starvation counter = `STARVE_LIM`. In that case sweep wins and the counter clears.
- The counter increments on each host-read grant while a sweep read is pending. It clears on any sweep grant and in IDLE.
- Idle read port: `mem_raddr` holds its last value.

Read return:
- A 1-bit registered tag records who owns each issued read.
- One cycle after issue:
  - host-owned: `h_rdata` ← `mem_dout` and `h_rvalid`=1 for 1 cycle;
  - sweep-owned: `sweep_sum` ← `sweep_sum` + zero-extended `mem_dout`, modulo 2^`SUM_W`.

Collisions and boundaries:
- A host write and a sweep read to the same address in the same cycle return the old data (read-first).
- The checksum reflects whatever the RAM held when each address was read.
- Address counter width is `ADDR_W`+1, so `DEPTH_MEM` = 2^`ADDR_W` terminates without wrap ambiguity.

Timing:
- Uncontended sweep: `start_sweep` sampled at edge T.
- Reads are issued in cycles T+1 .. T+`DEPTH_MEM`.
- Final accumulation happens at edge T+`DEPTH_MEM`+1.
- `sweep_done` is high in cycle T+`DEPTH_MEM`+2.

Test Plan:
1. RAM initialised all 0x1FF, pulse `start_sweep`, no host traffic → `sweep_done` 8194 cycles after start, `sweep_sum` = 0x003FE000, `sweep_busy` low afterwards.
2. Host write addr 0x0005 data 0x0AA, then host read 0x0005 in IDLE → `h_gnt`=1 both cycles, `mem_we`=1 for 1 cycle, `h_rvalid`=1 with `h_rdata`=0x0AA one cycle after the read grant.
3. Continuous host reads during a sweep → repeating pattern of 4 host grants then 1 sweep grant; `sweep_done` about 5×8192 cycles after start; checksum equals the uncontended value.
4. Host write of 0x000 to addr 0x0010 in the same cycle the sweep reads 0x0010 (init 0x1FF) → checksum includes 0x1FF; a later host read of 0x0010 returns 0x000.
5. Assert `reset` at counter 0x0800 mid-sweep → next cycle IDLE, `sweep_busy`=0, `sweep_sum`=0, no `sweep_done`. A new `start_sweep` completes normally.
6. `start_sweep` re-pulsed while busy → ignored, exactly one `sweep_done`, result identical to scenario 1.
